mips_muldiv: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Operand width is parametrised, which generalises the fixed 32-bit datapath.
- Sits beside the ALU in the execute stage. The core stalls on busy_o and reads hi_o/lo_o for MFHI/MFLO.
- Radix-2 shift-add multiply and restoring divide: one bit per clock.

---
 rtl/mips_muldiv.sv | 187 ++++++++++++++++++
 tb/tb_mips_muldiv.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, plus single-cycle MTHI/MTLO writes.
module mips_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             is_div_q, is_div_d;
    logic             neg_pq_q, neg_pq_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_signed;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand magnitudes, one iteration step and the final sign correction
    always_comb begin
        is_signed = ~op_i[0];
        a_abs     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;

        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

        div_sh    = {rem_q, acc_q[WIDTH-1]};
        div_sub   = div_sh - {1'b0, opd_q};
        div_ge    = (div_sh >= {1'b0, opd_q});
        div_rem   = WIDTH'(div_ge ? div_sub : div_sh);

        prod_fix  = neg_pq_q ? -acc_q : acc_q;
        // A zero divisor yields all-ones naturally; pin it so the sign fix cannot disturb it
        quo_fix   = dz_q ? '1 : (neg_pq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix   = neg_r_q ? -rem_q : rem_q;
    end

    // Next-state and register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_pq_d = neg_pq_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (!op_i[2]) begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        rem_d    = '0;
                        is_div_d = op_i[1];
                        neg_pq_d = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_r_d  = is_signed & a_i[WIDTH-1];
                        dz_d     = (b_i == '0);
                        if (op_i[1]) begin
                            opd_d = b_abs;
                            acc_d = {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            opd_d = a_abs;
                            acc_d = {{WIDTH{1'b0}}, b_abs};
                        end
                    end else if (op_i[1:0] == 2'b00) begin
                        hi_d   = a_i;
                        done_d = 1'b1;
                    end else if (op_i[1:0] == 2'b01) begin
                        lo_d   = a_i;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                        rem_d = div_rem;
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[ACC_W-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_pq_q <= neg_pq_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv (WIDTH=32): directed corner cases plus random operations
// compared against a plain-arithmetic HI/LO model.
module tb_mips_muldiv;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;

    logic         clk_tb = 1'b0;
    logic         rst_tb;
    logic         start_tb;
    logic [2:0]   op_tb;
    logic [W-1:0] a_tb, b_tb;
    logic         flush_tb;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk_i  (clk_tb),
        .rst_i  (rst_tb),
        .start_i(start_tb),
        .op_i   (op_tb),
        .a_i    (a_tb),
        .b_i    (b_tb),
        .flush_i(flush_tb),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Architectural HI/LO effect of one operation
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb, q, r;
        logic [63:0]  prod;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin
                prod = 64'(sa * sb);
                exp_hi = prod[63:32];
                exp_lo = prod[31:0];
            end
            3'd1: begin
                prod = {32'd0, a} * {32'd0, b};
                exp_hi = prod[63:32];
                exp_lo = prod[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    exp_hi = a;
                    exp_lo = '1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = W'(q);
                    exp_hi = W'(r);
                end
            end
            3'd3: begin
                if (b == 0) begin
                    exp_hi = a;
                    exp_lo = '1;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op now (away from the edge), wait for done and check latency/result
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int   cyc;
        logic busy_bad;
        start_tb = 1'b1;
        op_tb    = op;
        a_tb     = a;
        b_tb     = b;
        @(posedge clk_tb);
        #1;
        start_tb = 1'b0;
        model(op, a, b);
        cyc      = 0;
        busy_bad = 1'b0;
        while (!done && cyc < 200) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk_tb);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'((op < 3'd4) ? LAT : 0));
        if (op < 3'd4) check({tag, " busy_during"}, 64'(busy_bad), 64'(0));
        check({tag, " busy_at_done"}, 64'(busy), 64'(0));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         seen;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        int           sel;

        rst_tb   = 1'b0;
        start_tb = 1'b0;
        flush_tb = 1'b0;
        op_tb    = '0;
        a_tb     = '0;
        b_tb     = '0;
        exp_hi   = '0;
        exp_lo   = '0;
        repeat (2) @(posedge clk_tb);
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clk_tb);
        rst_tb = 1'b1;
        @(negedge clk_tb);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, "multu");
        run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_op(3'd3, 32'h1234_5678, 32'd0, "divu_by0");
        run_op(3'd2, 32'hFFFF_FF00, 32'd0, "div_by0_neg");

        // MTHI then MTLO on consecutive cycles
        @(negedge clk_tb);
        start_tb = 1'b1;
        op_tb    = 3'd4;
        a_tb     = 32'hCAFE_F00D;
        @(posedge clk_tb);
        #1;
        exp_hi = 32'hCAFE_F00D;
        check("mthi done", 64'(done), 64'(1));
        check("mthi busy", 64'(busy), 64'(0));
        check("mthi hi", 64'(hi), 64'(exp_hi));
        op_tb = 3'd5;
        a_tb  = 32'h0BAD_BEEF;
        @(posedge clk_tb);
        #1;
        start_tb = 1'b0;
        exp_lo = 32'h0BAD_BEEF;
        check("mtlo done", 64'(done), 64'(1));
        check("mtlo busy", 64'(busy), 64'(0));
        check("mtlo lo", 64'(lo), 64'(exp_lo));
        check("mtlo hi kept", 64'(hi), 64'(exp_hi));
        @(posedge clk_tb);
        #1;
        check("mtx done pulse", 64'(done), 64'(0));

        // Reserved opcodes change nothing
        for (int k = 6; k < 8; k++) begin
            start_tb = 1'b1;
            op_tb    = 3'(k);
            a_tb     = 32'h5555_AAAA;
            @(posedge clk_tb);
            #1;
            start_tb = 1'b0;
            seen = 1'b0;
            repeat (3) begin
                if (done || busy) seen = 1'b1;
                @(posedge clk_tb);
                #1;
            end
            check("reserved activity", 64'(seen), 64'(0));
            check("reserved hi", 64'(hi), 64'(exp_hi));
            check("reserved lo", 64'(lo), 64'(exp_lo));
        end

        // Ignored start during RUN, then flush at iteration 15
        start_tb = 1'b1;
        op_tb    = 3'd0;
        a_tb     = 32'd1234;
        b_tb     = 32'd5678;
        @(posedge clk_tb);
        #1;
        start_tb = 1'b0;
        repeat (9) begin
            @(posedge clk_tb);
            #1;
        end
        start_tb = 1'b1;
        op_tb    = 3'd3;
        a_tb     = 32'd1;
        b_tb     = 32'd1;
        @(posedge clk_tb);
        #1;
        start_tb = 1'b0;
        check("busy start ignored", 64'(busy), 64'(1));
        repeat (4) begin
            @(posedge clk_tb);
            #1;
        end
        flush_tb = 1'b1;
        @(posedge clk_tb);
        #1;
        flush_tb = 1'b0;
        check("flush busy", 64'(busy), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk_tb);
            #1;
        end
        check("flush no done", 64'(seen), 64'(0));
        check("flush hi kept", 64'(hi), 64'(exp_hi));
        check("flush lo kept", 64'(lo), 64'(exp_lo));
        run_op(3'd3, 32'd9, 32'd3, "divu_9_3");

        // Asynchronous reset at iteration 20 of a DIV
        start_tb = 1'b1;
        op_tb    = 3'd2;
        a_tb     = 32'hF000_0001;
        b_tb     = 32'd77;
        @(posedge clk_tb);
        #1;
        start_tb = 1'b0;
        repeat (20) begin
            @(posedge clk_tb);
            #1;
        end
        #2;
        rst_tb = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        check("midrst hi", 64'(hi), 64'(0));
        check("midrst lo", 64'(lo), 64'(0));
        @(negedge clk_tb);
        rst_tb = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_tb);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrst no done", 64'(seen), 64'(0));
        run_op(3'd0, 32'd5, 32'd5, "mult_5x5");

        // Random back-to-back operations
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                ra = ra >> $urandom_range(0, 31);
                rb = rb >> $urandom_range(16, 31);
            end
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
